// File: rtl/bus_master_if.sv
// bus_master_if: host command/response handshake plus the packed slave bus
interface bus_master_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32,
   parameter int IN_W   = ADDR_W + DATA_W + 4,
   parameter int OUT_W  = DATA_W + 3
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_wr;
   logic [ADDR_W-1:0] cmd_addr;
   logic [31:0]       cmd_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic [IN_W-1:0]   bus_in;
   logic [OUT_W-1:0]  bus_out;
   logic              irq;

   modport master (
      input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, bus_out,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, bus_in, irq
   );

   modport slave (
      output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, bus_out,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, bus_in, irq
   );
endinterface

// File: rtl/bus_master.sv
// bus_master: turns host commands into single bus accesses with ack timeout
module bus_master #(
   parameter int TIMEOUT        = 255,
   parameter int BUS_ADDR_WIDTH = 8,
   parameter int BUS_DATA_WIDTH = 32
) (
   input logic           bus_clk,
   input logic           bus_reset_l,
   bus_master_if.master  bus
);
   // bus_out layout, LSB first: irq, wr_ack, rd_ack, read data
   localparam int OUT_IRQ    = 0;
   localparam int OUT_WR_ACK = 1;
   localparam int OUT_RD_ACK = 2;
   localparam int OUT_RDATA  = 3;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_t;

   state_t                    state, nxt;
   logic [7:0]                cnt;
   logic                      rdy_q;
   logic                      wr_q;
   logic [BUS_ADDR_WIDTH-1:0] addr_q;
   logic [BUS_DATA_WIDTH-1:0] wdata_q;
   logic                      rd_req_q, wr_req_q;
   logic [BUS_DATA_WIDTH-1:0] rdata_q;
   logic                      err_q;
   logic                      irq_q;
   logic                      acc, hit, tmo;

   assign acc = bus.cmd_valid && bus.cmd_ready;
   assign hit = wr_q ? bus.bus_out[OUT_WR_ACK] : bus.bus_out[OUT_RD_ACK];
   assign tmo = cnt == 8'(TIMEOUT - 1);

   // bus_in layout, MSB first: clock, reset, addr, rd_req, wr_req, wr_data
   assign bus.bus_in    = {bus_clk, bus_reset_l, addr_q, rd_req_q, wr_req_q, wdata_q};
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;
   assign bus.irq       = irq_q;

   // state register
   always_ff @(posedge bus_clk or negedge bus_reset_l) begin
      if (!bus_reset_l) state <= IDLE;
      else              state <= nxt;
   end

   // next state and handshake outputs; ready is held off until the first clock after reset
   always_comb begin
      nxt           = state;
      bus.cmd_ready = (state == IDLE) && rdy_q;
      bus.rsp_valid = state == RSP;
      case (state)
         IDLE:    if (acc) nxt = REQ;
         REQ:     nxt = WAIT;
         WAIT:    if (hit || tmo) nxt = RSP;
         default: if (bus.rsp_ready) nxt = IDLE;
      endcase
   end

   // command latch, one-cycle request strobes, wait counter and response capture
   always_ff @(posedge bus_clk or negedge bus_reset_l) begin
      if (!bus_reset_l) begin
         rdy_q    <= 1'b0;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rd_req_q <= 1'b0;
         wr_req_q <= 1'b0;
         cnt      <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         rdy_q    <= 1'b1;
         rd_req_q <= acc && !bus.cmd_wr;
         wr_req_q <= acc && bus.cmd_wr;
         if (acc) begin
            wr_q    <= bus.cmd_wr;
            addr_q  <= bus.cmd_addr;
            wdata_q <= bus.cmd_wr ? BUS_DATA_WIDTH'(bus.cmd_wdata) : '0;
         end
         if (state == REQ) cnt <= '0;
         else if (state == WAIT && !hit) cnt <= cnt + 8'd1;
         if (state == WAIT && (hit || tmo)) begin
            err_q   <= !hit;
            rdata_q <= (hit && !wr_q) ? bus.bus_out[OUT_RDATA +: BUS_DATA_WIDTH] : '0;
         end
      end
   end

   // irq is a plain one-stage resample of the slaves' irq line
   always_ff @(posedge bus_clk or negedge bus_reset_l) begin
      if (!bus_reset_l) irq_q <= 1'b0;
      else              irq_q <= bus.bus_out[OUT_IRQ];
   end
endmodule

// File: tb/tb_bus_master.sv
// tb_bus_master: directed scenario checks of bus_master against a small register slave
module tb_bus_master;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bus_master_if #(.ADDR_W(8), .DATA_W(32)) bif();

   bus_master #(.TIMEOUT(8), .BUS_ADDR_WIDTH(8), .BUS_DATA_WIDTH(32)) dut (
      .bus_clk(clk),
      .bus_reset_l(rst_n),
      .bus(bif.master)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic        slv_en = 1'b1;
   logic [15:0] s_reg = 16'h0;
   logic        s_rd = 1'b0, s_wr = 1'b0;
   logic [31:0] s_data = 32'h0;
   logic        f_rd = 1'b0, f_wr = 1'b0, f_irq = 1'b0;
   logic [31:0] f_data = 32'h0;

   logic [31:0] b_wdata;
   logic        b_wr, b_rd, b_rst;
   logic [7:0]  b_addr;
   assign b_wdata = bif.bus_in[31:0];
   assign b_wr    = bif.bus_in[32];
   assign b_rd    = bif.bus_in[33];
   assign b_addr  = bif.bus_in[41:34];
   assign b_rst   = bif.bus_in[42];
   assign bif.bus_out = {s_data | f_data, s_rd | f_rd, s_wr | f_wr, f_irq};

   // one-cycle slave with a masked-write register at 0x10
   always @(posedge clk) begin
      s_rd   <= slv_en && b_rd && b_addr == 8'h10;
      s_wr   <= slv_en && b_wr && b_addr == 8'h10;
      s_data <= (slv_en && b_rd && b_addr == 8'h10) ? {16'h0, s_reg} : 32'h0;
      if (slv_en && b_wr && b_addr == 8'h10)
         s_reg <= (s_reg & ~b_wdata[31:16]) | (b_wdata[15:0] & b_wdata[31:16]);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic wr, input logic [7:0] addr, input logic [31:0] wdata);
      bif.cmd_valid = 1'b1;
      bif.cmd_wr    = wr;
      bif.cmd_addr  = addr;
      bif.cmd_wdata = wdata;
      tick();
      bif.cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int cyc);
      cyc = -1;
      for (int i = 1; i <= 300; i++) begin
         tick();
         if (bif.rsp_valid) begin
            cyc = i;
            break;
         end
      end
   endtask

   task automatic take_rsp();
      bif.rsp_ready = 1'b1;
      tick();
      bif.rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      f_irq = 1'b1;
      tick();
      tick();
      n_cmp++; if (bif.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL reset_cmd_ready got %b want 0", bif.cmd_ready); end
      n_cmp++; if (bif.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got %b want 0", bif.rsp_valid); end
      n_cmp++; if (bif.irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq got %b want 0", bif.irq); end
      n_cmp++; if ({b_rd, b_wr, b_addr, b_wdata} !== 42'h0) begin n_bad++; $display("FAIL reset_bus_in got %h want 0", {b_rd, b_wr, b_addr, b_wdata}); end
      n_cmp++; if (b_rst !== 1'b0) begin n_bad++; $display("FAIL reset_field got %b want 0", b_rst); end
      f_irq = 1'b0;
      rst_n = 1'b1;
      tick();
      n_cmp++; if (bif.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL release_cmd_ready got %b want 1", bif.cmd_ready); end
   endtask

   task automatic test_irq();
      f_irq = 1'b1;
      #1;
      n_cmp++; if (bif.irq !== 1'b0) begin n_bad++; $display("FAIL irq_comb got %b want 0", bif.irq); end
      tick();
      n_cmp++; if (bif.irq !== 1'b1) begin n_bad++; $display("FAIL irq_set got %b want 1", bif.irq); end
      f_irq = 1'b0;
      tick();
      n_cmp++; if (bif.irq !== 1'b0) begin n_bad++; $display("FAIL irq_clr got %b want 0", bif.irq); end
   endtask

   task automatic test_masked_write();
      issue(1'b1, 8'h10, 32'h00FF_1234);
      n_cmp++; if ({b_wr, b_rd} !== 2'b10) begin n_bad++; $display("FAIL mw_req got %b want 10", {b_wr, b_rd}); end
      n_cmp++; if (b_addr !== 8'h10 || b_wdata !== 32'h00FF_1234) begin n_bad++; $display("FAIL mw_bus got %h/%h want 10/00ff1234", b_addr, b_wdata); end
      n_cmp++; if (bif.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL mw_cmd_ready got %b want 0", bif.cmd_ready); end
      tick();
      n_cmp++; if ({b_wr, bif.rsp_valid} !== 2'b00) begin n_bad++; $display("FAIL mw_n2 got %b want 00", {b_wr, bif.rsp_valid}); end
      n_cmp++; if (b_addr !== 8'h10 || b_wdata !== 32'h00FF_1234) begin n_bad++; $display("FAIL mw_hold got %h/%h want 10/00ff1234", b_addr, b_wdata); end
      tick();
      n_cmp++; if ({bif.rsp_valid, bif.rsp_err, bif.rsp_rdata} !== {2'b10, 32'h0}) begin n_bad++; $display("FAIL mw_rsp got %b/%b/%h want 1/0/0", bif.rsp_valid, bif.rsp_err, bif.rsp_rdata); end
      n_cmp++; if (s_reg !== 16'h0034) begin n_bad++; $display("FAIL mw_reg got %h want 0034", s_reg); end
      take_rsp();
      n_cmp++; if ({bif.rsp_valid, bif.cmd_ready} !== 2'b01) begin n_bad++; $display("FAIL mw_done got %b want 01", {bif.rsp_valid, bif.cmd_ready}); end
   endtask

   task automatic test_read();
      int cyc;
      issue(1'b1, 8'h10, 32'hFFFF_ABCD);
      wait_rsp(cyc);
      take_rsp();
      issue(1'b0, 8'h10, 32'h1234_5678);
      n_cmp++; if ({b_rd, b_wr} !== 2'b10) begin n_bad++; $display("FAIL rd_req got %b want 10", {b_rd, b_wr}); end
      n_cmp++; if (b_wdata !== 32'h0) begin n_bad++; $display("FAIL rd_wdata got %h want 0", b_wdata); end
      wait_rsp(cyc);
      n_cmp++; if (cyc !== 2) begin n_bad++; $display("FAIL rd_latency got %0d want 2", cyc); end
      n_cmp++; if (bif.rsp_rdata !== 32'hABCD || bif.rsp_err !== 1'b0) begin n_bad++; $display("FAIL rd_data got %h/%b want abcd/0", bif.rsp_rdata, bif.rsp_err); end
      take_rsp();
   endtask

   task automatic test_wrong_ack();
      slv_en = 1'b0;
      f_wr = 1'b1;
      tick();
      f_wr = 1'b0;
      n_cmp++; if ({bif.rsp_valid, bif.cmd_ready} !== 2'b01) begin n_bad++; $display("FAIL idle_ack got %b want 01", {bif.rsp_valid, bif.cmd_ready}); end
      issue(1'b1, 8'h20, 32'h5);
      tick();
      f_rd = 1'b1;
      f_data = 32'hDEAD;
      tick();
      f_rd = 1'b0;
      f_data = 32'h0;
      n_cmp++; if (bif.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL wa_rd_ack got %b want 0", bif.rsp_valid); end
      tick();
      tick();
      f_wr = 1'b1;
      tick();
      f_wr = 1'b0;
      n_cmp++; if ({bif.rsp_valid, bif.rsp_err, bif.rsp_rdata} !== {2'b10, 32'h0}) begin n_bad++; $display("FAIL wa_rsp got %b/%b/%h want 1/0/0", bif.rsp_valid, bif.rsp_err, bif.rsp_rdata); end
      take_rsp();
      slv_en = 1'b1;
   endtask

   task automatic test_timeout();
      int cyc;
      issue(1'b0, 8'h7C, 32'h0);
      wait_rsp(cyc);
      n_cmp++; if (cyc !== 9) begin n_bad++; $display("FAIL to_latency got %0d want 9", cyc); end
      n_cmp++; if (bif.rsp_err !== 1'b1 || bif.rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL to_rsp got %b/%h want 1/0", bif.rsp_err, bif.rsp_rdata); end
      take_rsp();
      n_cmp++; if (bif.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL to_idle got %b want 1", bif.cmd_ready); end
   endtask

   task automatic test_timeout_ack_wins();
      issue(1'b0, 8'h7C, 32'h0);
      repeat (8) tick();
      n_cmp++; if (bif.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL tw_early got %b want 0", bif.rsp_valid); end
      f_rd = 1'b1;
      f_data = 32'h55;
      tick();
      f_rd = 1'b0;
      f_data = 32'h0;
      n_cmp++; if ({bif.rsp_valid, bif.rsp_err, bif.rsp_rdata} !== {2'b10, 32'h55}) begin n_bad++; $display("FAIL tw_rsp got %b/%b/%h want 1/0/55", bif.rsp_valid, bif.rsp_err, bif.rsp_rdata); end
      take_rsp();
   endtask

   task automatic test_back_pressure();
      int cyc;
      issue(1'b0, 8'h10, 32'h0);
      wait_rsp(cyc);
      n_cmp++; if (cyc !== 2) begin n_bad++; $display("FAIL bp_latency got %0d want 2", cyc); end
      bif.cmd_valid = 1'b1;
      bif.cmd_wr = 1'b1;
      bif.cmd_addr = 8'h10;
      bif.cmd_wdata = 32'hFFFF_0000;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_cmp++; if ({bif.rsp_valid, bif.cmd_ready, b_rd, b_wr} !== 4'b1000) begin n_bad++; $display("FAIL bp_hold%0d got %b want 1000", i, {bif.rsp_valid, bif.cmd_ready, b_rd, b_wr}); end
         n_cmp++; if (bif.rsp_rdata !== 32'hABCD) begin n_bad++; $display("FAIL bp_data%0d got %h want abcd", i, bif.rsp_rdata); end
      end
      bif.cmd_valid = 1'b0;
      take_rsp();
      n_cmp++; if (bif.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_done got %b want 0", bif.rsp_valid); end
   endtask

   task automatic test_reset_mid();
      int cyc;
      slv_en = 1'b0;
      f_irq = 1'b1;
      issue(1'b0, 8'h10, 32'h0);
      tick();
      tick();
      n_cmp++; if (bif.irq !== 1'b1) begin n_bad++; $display("FAIL rm_irq_pre got %b want 1", bif.irq); end
      rst_n = 1'b0;
      #1;
      n_cmp++; if ({bif.cmd_ready, bif.rsp_valid, bif.rsp_err, bif.irq} !== 4'b0) begin n_bad++; $display("FAIL rm_ctl got %b want 0000", {bif.cmd_ready, bif.rsp_valid, bif.rsp_err, bif.irq}); end
      n_cmp++; if (bif.rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL rm_rdata got %h want 0", bif.rsp_rdata); end
      n_cmp++; if ({b_rd, b_wr, b_addr, b_wdata} !== 42'h0) begin n_bad++; $display("FAIL rm_bus got %h want 0", {b_rd, b_wr, b_addr, b_wdata}); end
      tick();
      f_irq = 1'b0;
      rst_n = 1'b1;
      f_rd = 1'b1;
      f_data = 32'h77;
      tick();
      f_rd = 1'b0;
      f_data = 32'h0;
      n_cmp++; if ({bif.rsp_valid, bif.cmd_ready} !== 2'b01) begin n_bad++; $display("FAIL rm_late_ack got %b want 01", {bif.rsp_valid, bif.cmd_ready}); end
      tick();
      n_cmp++; if (bif.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rm_no_rsp got %b want 0", bif.rsp_valid); end
      slv_en = 1'b1;
      issue(1'b0, 8'h10, 32'h0);
      wait_rsp(cyc);
      n_cmp++; if (cyc !== 2 || bif.rsp_rdata !== 32'hABCD) begin n_bad++; $display("FAIL rm_next got %0d/%h want 2/abcd", cyc, bif.rsp_rdata); end
      take_rsp();
   endtask

   initial begin
      bif.cmd_valid = 1'b0;
      bif.cmd_wr    = 1'b0;
      bif.cmd_addr  = 8'h0;
      bif.cmd_wdata = 32'h0;
      bif.rsp_ready = 1'b0;
      test_reset();
      test_irq();
      test_masked_write();
      test_read();
      test_wrong_ack();
      test_timeout();
      test_timeout_ack_wins();
      test_back_pressure();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/bus_master.md
BUS_MASTER -- requirements
Module: bus_master

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum number of cycles to wait for an ack before the access is failed (1..255).
REQ-002 Parameter BUS_ADDR_WIDTH, BUS_DATA_WIDTH, BUS_IN_WIDTH, BUS_OUT_WIDTH and field positions SHALL come from bus_params.v.
REQ-003 bus_clk  input  1  single clock for all logic; also forwarded in the bus_in clock field.
REQ-004 bus_reset_l  input  1  asynchronous, active-low reset; also forwarded in the bus_in reset field.
REQ-005 cmd_valid  input  1  host command present.
REQ-006 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-007 cmd_wr  input  1  1 = write, 0 = read.
REQ-008 cmd_addr  input  BUS_ADDR_WIDTH  byte address, 4-byte aligned.
REQ-009 cmd_wdata  input  32  write data; upper 16 bits are the mask for masked-write registers.
REQ-010 rsp_valid / rsp_ready  output / input  1 / 1  response handshake.
REQ-011 rsp_rdata  output  BUS_DATA_WIDTH  read data; 0 for writes and errors.
REQ-012 rsp_err  output  1  1 = access timed out.
REQ-013 bus_in  output  BUS_IN_WIDTH  packed bus to all slaves: clock, reset, bus_addr, bus_rd_req, bus_wr_req, bus_wr_data.
REQ-014 bus_out  input  BUS_OUT_WIDTH  OR of all slave outputs: read data, rd_ack, wr_ack, irq.
REQ-015 irq  output  1  registered copy of the bus_out IRQ field.

Function
REQ-016 FSM states IDLE, REQ, WAIT, RSP; cmd_ready SHALL be 1 only in IDLE.
REQ-017 IDLE: on cmd_valid, latch cmd_wr/addr/wdata and go to REQ.
REQ-018 REQ: assert exactly one of bus_rd_req / bus_wr_req for exactly one cycle, clear the wait counter, and go to WAIT.
REQ-019 bus_addr and bus_wr_data SHALL hold the latched values from REQ through the end of WAIT; bus_wr_data SHALL be 0 for reads.
REQ-020 WAIT: an ack of the matching type (rd_ack for a read, wr_ack for a write) ends the access.
  - On a read ack, capture the read-data field into rsp_rdata.
  - Set rsp_err=0 and go to RSP.
REQ-021 WAIT: an ack of the wrong type, or any ack seen in IDLE or REQ, SHALL be ignored.
REQ-022 WAIT: the counter increments each cycle without a matching ack.
  - When it reaches TIMEOUT with no ack, set rsp_err=1, rsp_rdata=0, and go to RSP.
  - An ack arriving in the same cycle the counter reaches TIMEOUT SHALL win (rsp_err=0).
REQ-023 RSP: rsp_valid=1 with rsp_rdata/rsp_err held stable until rsp_ready; on rsp_valid && rsp_ready, go to IDLE.
REQ-024 Latency with a one-cycle slave: accept at cycle N, req at N+1, ack at N+2, rsp_valid at N+3.
REQ-025 Request strobes SHALL be registered outputs; no combinational path from cmd_* to bus_in.
REQ-026 irq SHALL be bus_out IRQ delayed by one register stage, independent of the FSM.

Reset
REQ-027 Asserting bus_reset_l low at any time SHALL immediately force the following:
  - state IDLE, counter 0;
  - cmd_ready=0 while in reset, then 1 on the first clock after release;
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, irq=0;
  - bus_rd_req=0, bus_wr_req=0, bus_addr=0, bus_wr_data=0.
REQ-028 A reset mid-access SHALL abandon the access with no response; a late ack after reset release SHALL be ignored.

Verification
REQ-029 Masked write: cmd_wr=1, addr 0x10, wdata 0x00FF_1234 with a masked-write register at 0x10 (initial 0x0000) -> one-cycle bus_wr_req, rsp_valid at N+3, rsp_err=0, rsp_rdata=0, register=0x0034.
REQ-030 Read: addr 0x10, slave returns 0xABCD -> one-cycle bus_rd_req, rsp_rdata=0xABCD, rsp_err=0.
REQ-031 Timeout: TIMEOUT=8, read of an unmapped address 0x7C -> rsp_valid after 8 WAIT cycles, rsp_err=1, rsp_rdata=0, FSM returns to IDLE.
REQ-032 Back-pressure: rsp_ready held 0 for 5 cycles -> rsp_valid and data stable throughout, cmd_ready=0, no new bus request.
REQ-033 Wrong-ack: a write that receives rd_ack first, then wr_ack 3 cycles later -> completes on wr_ack, rsp_err=0.
REQ-034 Reset in WAIT, then an ack 1 cycle after release -> all outputs 0 during reset, no rsp_valid, next command behaves normally.
